// File: rtl/id_regfile_scoreboard.sv
// Decode register file with WB->ID bypass and a per-register pending-write scoreboard.
// Reads and stall are combinational (0 cycles); stall holds ID and the issue is ignored.
module id_regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS),
    parameter int NREAD = 2,
    parameter int CNTW  = 16
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic [NREAD*AW-1:0]   rs_addr,
    input  logic [NREAD-1:0]      rs_used,
    output logic [NREAD*XLEN-1:0] rs_data,
    input  logic                  iss_valid,
    input  logic                  iss_wr,
    input  logic [AW-1:0]         iss_rd,
    input  logic                  wb_en,
    input  logic [AW-1:0]         wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic                  stall,
    output logic [CNTW-1:0]       stall_cnt,
    input  logic [AW-1:0]         test_addr,
    output logic [XLEN-1:0]       test_data
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] pend_q, pend_d;
    logic [CNTW-1:0]  stall_cnt_q, stall_cnt_d;
    logic             raw_hit;
    logic             waw_hit;
    logic             wb_wr;
    logic             iss_set;

    assign wb_wr = wb_en && (wb_rd != '0);

    // A same-cycle writeback to the source satisfies the dependency via the bypass.
    always_comb begin
        rs_data = '0;
        raw_hit = 1'b0;
        for (int i = 0; i < NREAD; i++) begin
            if (rs_addr[i*AW +: AW] != '0) begin
                if (wb_en && (wb_rd == rs_addr[i*AW +: AW]))
                    rs_data[i*XLEN +: XLEN] = wb_data;
                else
                    rs_data[i*XLEN +: XLEN] = regs_q[rs_addr[i*AW +: AW]];
            end
            if (rs_used[i] && pend_q[rs_addr[i*AW +: AW]] &&
                !(wb_en && (wb_rd == rs_addr[i*AW +: AW])))
                raw_hit = 1'b1;
        end
    end

    always_comb begin
        waw_hit = iss_valid && iss_wr && (iss_rd != '0) && pend_q[iss_rd] &&
                  !(wb_en && (wb_rd == iss_rd));
        stall   = raw_hit || waw_hit;
        iss_set = iss_valid && !stall && iss_wr && (iss_rd != '0);
    end

    // Set is applied after clear so a younger producer wins over a retiring one.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wb_wr) begin
            regs_d[wb_rd] = wb_data;
            pend_d[wb_rd] = 1'b0;
        end
        if (iss_set)
            pend_d[iss_rd] = 1'b1;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNTW{1'b1}}))
            stall_cnt_d = stall_cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++)
                regs_q[r] <= '0;
            pend_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            regs_q      <= regs_d;
            pend_q      <= pend_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign test_data = (test_addr == '0) ? '0 : regs_q[test_addr];

endmodule

// File: doc/id_regfile_scoreboard.md
Name: id_regfile_scoreboard

Overview:
- Parametrised decode-stage register file for the pipelined core: NREAD read ports, one writeback port, WB→ID same-cycle bypass.
- Adds a per-register pending-write scoreboard: ID marks a destination pending at issue, and WB clears it.
- Generates a decode stall on RAW and WAW hazards against long-latency producers.
- Provides a saturating stall-cycle counter and a debug read port for the testbench.

Parameters:
- XLEN, 32, data width.
- NREGS, 32, number of architectural registers; must be a power of two, ≥2; register 0 is hardwired zero.
- AW, $clog2(NREGS), register address width.
- NREAD, 2, number of read ports (1..4).
- CNTW, 16, stall counter width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs_addr  in  NREAD*AW  packed read addresses; port i = bits [i*AW +: AW].
- rs_used  in  NREAD  port i is consumed by the decoding instruction.
- rs_data  out  NREAD*XLEN  packed read data, combinational.
- iss_valid  in  1  decoding instruction leaves ID this cycle.
- iss_wr  in  1  issuing instruction writes a register through the scoreboard.
- iss_rd  in  AW  issuing destination register.
- wb_en  in  1  writeback enable.
- wb_rd  in  AW  writeback destination.
- wb_data  in  XLEN  writeback data.
- stall  out  1  hazard; ID must hold and the block ignores the issue.
- stall_cnt  out  CNTW  cycles with stall=1, saturating.
- test_addr  in  AW  debug read address.
- test_data  out  XLEN  debug read data (array value, no bypass).

Behaviour:
- Reset (rst_n=0, async): all registers=0, all pending bits=0, stall_cnt=0. Outputs then follow the combinational rules below.
- Register 0: reads 0 on every port, including test_data. Writes to it are discarded. It is never marked pending.
- Write: on the edge with wb_en=1 and wb_rd≠0, reg[wb_rd]<=wb_data and pending[wb_rd]<=0. The write is visible in the array next cycle.
- Bypass: rs_data[i] = wb_data if wb_en && wb_rd==rs_addr[i] && rs_addr[i]≠0; otherwise the array value. Latency 0.
- RAW hazard, port i: rs_used[i] && pending[rs_addr[i]] && !(wb_en && wb_rd==rs_addr[i]). A same-cycle WB satisfies the dependency through the bypass.
- WAW hazard: iss_valid && iss_wr && iss_rd≠0 && pending[iss_rd] && !(wb_en && wb_rd==iss_rd).
- stall = OR of all RAW hazards OR the WAW hazard. Combinational, independent of CLK.
- Issue accepted = iss_valid && !stall. On the edge: if accepted && iss_wr && iss_rd≠0, then pending[iss_rd]<=1.
- Simultaneous accepted issue and WB to the same register: set wins (pending=1). The new producer is younger.
- Invariant: at most one outstanding write per register, guaranteed by the WAW stall.
- When stall=1, iss_valid has no effect on state.
- stall_cnt increments on each edge where stall=1 and holds at 2^CNTW−1. It is never cleared except by reset.
- Reset mid-operation clears pending and register contents immediately, regardless of in-flight writes.
- Out-of-range addresses cannot occur because NREGS is a power of two.

Test Plan:
- Reset then read all regs on every port and test_data → all 0; stall=0; stall_cnt=0.
- WB x5=0xDEADBEEF with rs_addr0=5 in the same cycle → rs_data0=0xDEADBEEF same cycle; next cycle test_addr=5 → 0xDEADBEEF. WB x0=0x1234 → x0 still reads 0.
- Issue iss_rd=7 (iss_wr=1). Next 3 cycles decode with rs_addr1=7, rs_used1=1 → stall=1 each cycle, stall_cnt=3. WB x7=0x55 → stall=0 that cycle, rs_data1=0x55.
- Same setup with rs_used1=0 → stall=0 despite pending x7.
- x9 pending, issue iss_rd=9 → stall=1, WAW. Same cycle wb_rd=9 → stall=0 and the issue is accepted; after the edge pending[9]=1 (set wins).
- With CNTW=4, hold a hazard for 20 cycles → stall_cnt=15. Assert rst_n=0 asynchronously mid-stall → stall_cnt, registers and pending clear immediately; stall=0.
